// File: rtl/text_memory_arbiter.sv
// text_memory_arbiter
// Shares the single-ported, synchronous-read text memory between instruction
// fetch and a data-side reader. Each port has a one-deep response slot with a
// hold register so a stalled response survives the memory being re-addressed.
module text_memory_arbiter #(
  parameter logic [31:0] TEXT_BEGIN   = 32'h0040_0000,
  parameter logic [31:0] TEXT_END     = 32'h0040_FFFF,
  parameter int          STARVE_LIMIT = 4
) (
  input  logic        clock,
  input  logic        reset,
  // fetch port
  input  logic        if_req_valid,
  output logic        if_req_ready,
  input  logic [31:0] if_req_addr,
  output logic        if_rsp_valid,
  input  logic        if_rsp_ready,
  output logic [31:0] if_rsp_data,
  output logic        if_rsp_error,
  // data port
  input  logic        dt_req_valid,
  output logic        dt_req_ready,
  input  logic [31:0] dt_req_addr,
  output logic        dt_rsp_valid,
  input  logic        dt_rsp_ready,
  output logic [31:0] dt_rsp_data,
  output logic        dt_rsp_error,
  // text memory
  output logic [13:0] mem_address,
  input  logic [31:0] mem_q
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    INFLIGHT = 2'd1,
    HOLD     = 2'd2
  } port_state_t;

  port_state_t if_state, if_state_next;
  port_state_t dt_state, dt_state_next;

  logic             if_in_range, dt_in_range;
  logic             if_slot_free, dt_slot_free;
  logic             if_cand, dt_cand;
  logic             if_grant, dt_grant;
  logic             if_err_q, dt_err_q;
  logic [31:0]      if_hold, dt_hold;
  logic [13:0]      last_address;
  logic [CNT_W-1:0] starve_cnt;

  // Range and alignment decode for both request ports.
  always_comb begin
    if_in_range = (if_req_addr >= TEXT_BEGIN) && (if_req_addr <= TEXT_END) &&
                  (if_req_addr[1:0] == 2'b00);
    dt_in_range = (dt_req_addr >= TEXT_BEGIN) && (dt_req_addr <= TEXT_END) &&
                  (dt_req_addr[1:0] == 2'b00);
  end

  // Arbitration: fetch wins by default, data wins when starved or when fetch
  // cannot use the memory; a port whose slot is full never takes the grant.
  always_comb begin
    if_slot_free = (if_state == IDLE) || (if_rsp_valid && if_rsp_ready);
    dt_slot_free = (dt_state == IDLE) || (dt_rsp_valid && dt_rsp_ready);
    if_cand      = !reset && if_req_valid && if_in_range && if_slot_free;
    dt_cand      = !reset && dt_req_valid && dt_in_range && dt_slot_free;
    dt_grant     = dt_cand && ((starve_cnt == CNT_MAX) || !if_cand);
    if_grant     = if_cand && !dt_grant;
    if_req_ready = !reset && if_slot_free &&
                   ((if_req_valid && !if_in_range) || if_grant);
    dt_req_ready = !reset && dt_slot_free &&
                   ((dt_req_valid && !dt_in_range) || dt_grant);
    if (if_grant) begin
      mem_address = if_req_addr[15:2];
    end else if (dt_grant) begin
      mem_address = dt_req_addr[15:2];
    end else begin
      mem_address = last_address;
    end
  end

  // Per-port state registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      if_state <= IDLE;
      dt_state <= IDLE;
    end else begin
      if_state <= if_state_next;
      dt_state <= dt_state_next;
    end
  end

  // Next-state logic: an accept always (re)enters INFLIGHT, otherwise an
  // unconsumed response parks in HOLD until the consumer takes it.
  always_comb begin
    if_state_next = if_state;
    dt_state_next = dt_state;
    if (if_req_ready) begin
      if_state_next = INFLIGHT;
    end else if (if_state != IDLE) begin
      if_state_next = if_rsp_ready ? IDLE : HOLD;
    end
    if (dt_req_ready) begin
      dt_state_next = INFLIGHT;
    end else if (dt_state != IDLE) begin
      dt_state_next = dt_rsp_ready ? IDLE : HOLD;
    end
  end

  // Response outputs come only from state, the error flag, the hold register
  // and mem_q, so there is no combinational path from the request side.
  always_comb begin
    if_rsp_valid = (if_state != IDLE);
    dt_rsp_valid = (dt_state != IDLE);
    if_rsp_error = if_rsp_valid && if_err_q;
    dt_rsp_error = dt_rsp_valid && dt_err_q;
    case (if_state)
      INFLIGHT: if_rsp_data = if_err_q ? 32'h0 : mem_q;
      HOLD:     if_rsp_data = if_hold;
      default:  if_rsp_data = 32'h0;
    endcase
    case (dt_state)
      INFLIGHT: dt_rsp_data = dt_err_q ? 32'h0 : mem_q;
      HOLD:     dt_rsp_data = dt_hold;
      default:  dt_rsp_data = 32'h0;
    endcase
  end

  // Error flags latch on accept; hold registers capture the live response the
  // first cycle it is not consumed, before the other port can re-address memory.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      if_err_q <= 1'b0;
      dt_err_q <= 1'b0;
      if_hold  <= 32'h0;
      dt_hold  <= 32'h0;
    end else begin
      if (if_req_ready) begin
        if_err_q <= !if_in_range;
      end
      if (dt_req_ready) begin
        dt_err_q <= !dt_in_range;
      end
      if (if_state == INFLIGHT && !if_rsp_ready) begin
        if_hold <= if_err_q ? 32'h0 : mem_q;
      end
      if (dt_state == INFLIGHT && !dt_rsp_ready) begin
        dt_hold <= dt_err_q ? 32'h0 : mem_q;
      end
    end
  end

  // Remember the last granted word address so the memory stays parked on it.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      last_address <= 14'h0;
    end else if (if_grant || dt_grant) begin
      last_address <= mem_address;
    end
  end

  // Starvation counter: counts cycles an in-range data request waits, clears
  // when data is served or stops asking; error requests leave it untouched.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (!dt_req_valid || (dt_req_ready && dt_in_range)) begin
      starve_cnt <= '0;
    end else if (dt_in_range && (starve_cnt != CNT_MAX)) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_text_memory_arbiter.sv
// Testbench for text_memory_arbiter: directed vectors with a response
// scoreboard per port and a simple synchronous-read text memory model.
module tb_text_memory_arbiter;

  logic        clock;
  logic        reset;
  logic        if_req_valid, if_req_ready, if_rsp_valid, if_rsp_ready, if_rsp_error;
  logic [31:0] if_req_addr, if_rsp_data;
  logic        dt_req_valid, dt_req_ready, dt_rsp_valid, dt_rsp_ready, dt_rsp_error;
  logic [31:0] dt_req_addr, dt_rsp_data;
  logic [13:0] mem_address;
  logic [31:0] mem_q;

  int checks = 0;
  int errors = 0;

  logic [32:0] if_q[$];
  logic [32:0] dt_q[$];

  text_memory_arbiter dut (
    .clock        (clock),
    .reset        (reset),
    .if_req_valid (if_req_valid),
    .if_req_ready (if_req_ready),
    .if_req_addr  (if_req_addr),
    .if_rsp_valid (if_rsp_valid),
    .if_rsp_ready (if_rsp_ready),
    .if_rsp_data  (if_rsp_data),
    .if_rsp_error (if_rsp_error),
    .dt_req_valid (dt_req_valid),
    .dt_req_ready (dt_req_ready),
    .dt_req_addr  (dt_req_addr),
    .dt_rsp_valid (dt_rsp_valid),
    .dt_rsp_ready (dt_rsp_ready),
    .dt_rsp_data  (dt_rsp_data),
    .dt_rsp_error (dt_rsp_error),
    .mem_address  (mem_address),
    .mem_q        (mem_q)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [31:0] mem_word(input logic [13:0] w);
    return 32'hC0DE_0000 | {18'd0, w};
  endfunction

  // Expected {error, data} for a request address.
  function automatic logic [32:0] exp_rsp(input logic [31:0] a);
    if (a >= 32'h0040_0000 && a <= 32'h0040_FFFF && a[1:0] == 2'b00)
      return {1'b0, mem_word(a[15:2])};
    return {1'b1, 32'h0};
  endfunction

  // Synchronous-read text memory model.
  always @(posedge clock) mem_q <= mem_word(mem_address);

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: checks responses mid-cycle, then records accepts.
  always @(negedge clock) begin
    if (reset) begin
      checkOutput("if_rsp_valid_in_reset", {31'd0, if_rsp_valid}, 32'd0);
      checkOutput("dt_rsp_valid_in_reset", {31'd0, dt_rsp_valid}, 32'd0);
      if_q.delete();
      dt_q.delete();
    end else begin
      if (if_rsp_valid) begin
        if (if_q.size() == 0) begin
          checkOutput("if_spurious_rsp", 32'd1, 32'd0);
        end else begin
          checkOutput("if_rsp_data", if_rsp_data, if_q[0][31:0]);
          checkOutput("if_rsp_error", {31'd0, if_rsp_error}, {31'd0, if_q[0][32]});
          if (if_rsp_ready) void'(if_q.pop_front());
        end
      end else if (if_q.size() != 0) begin
        checkOutput("if_rsp_missing", 32'd0, 32'd1);
        void'(if_q.pop_front());
      end
      if (dt_rsp_valid) begin
        if (dt_q.size() == 0) begin
          checkOutput("dt_spurious_rsp", 32'd1, 32'd0);
        end else begin
          checkOutput("dt_rsp_data", dt_rsp_data, dt_q[0][31:0]);
          checkOutput("dt_rsp_error", {31'd0, dt_rsp_error}, {31'd0, dt_q[0][32]});
          if (dt_rsp_ready) void'(dt_q.pop_front());
        end
      end else if (dt_q.size() != 0) begin
        checkOutput("dt_rsp_missing", 32'd0, 32'd1);
        void'(dt_q.pop_front());
      end
      if (if_req_valid && if_req_ready) if_q.push_back(exp_rsp(if_req_addr));
      if (dt_req_valid && dt_req_ready) dt_q.push_back(exp_rsp(dt_req_addr));
    end
  end

  // Drive one cycle of inputs just after the edge, check ready and the memory
  // address mid-cycle, then return just after the accepting edge.
  task automatic applyStimulus(input logic ifv, input logic [31:0] ifa, input logic ifrr,
                               input logic dtv, input logic [31:0] dta, input logic dtrr,
                               input logic exp_ifr, input logic exp_dtr,
                               input logic [13:0] exp_mem);
    if_req_valid = ifv;
    if_req_addr  = ifa;
    if_rsp_ready = ifrr;
    dt_req_valid = dtv;
    dt_req_addr  = dta;
    dt_rsp_ready = dtrr;
    @(negedge clock);
    checkOutput("if_req_ready", {31'd0, if_req_ready}, {31'd0, exp_ifr});
    checkOutput("dt_req_ready", {31'd0, dt_req_ready}, {31'd0, exp_dtr});
    checkOutput("mem_address", {18'd0, mem_address}, {18'd0, exp_mem});
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset        = 1'b1;
    if_req_valid = 1'b1;
    if_req_addr  = 32'h0040_0000;
    if_rsp_ready = 1'b1;
    dt_req_valid = 1'b1;
    dt_req_addr  = 32'h0040_0004;
    dt_rsp_ready = 1'b1;

    // Reset state: no ready, no response, memory parked at 0.
    @(negedge clock);
    checkOutput("reset_if_req_ready", {31'd0, if_req_ready}, 32'd0);
    checkOutput("reset_dt_req_ready", {31'd0, dt_req_ready}, 32'd0);
    checkOutput("reset_mem_address", {18'd0, mem_address}, 32'd0);
    checkOutput("reset_if_rsp_data", if_rsp_data, 32'd0);
    @(posedge clock);
    #1 reset = 1'b0;

    // Fetch only, back-to-back in range.
    applyStimulus(1, 32'h0040_0000, 1, 0, 32'h0, 1, 1, 0, 14'd0);
    applyStimulus(1, 32'h0040_0004, 1, 0, 32'h0, 1, 1, 0, 14'd1);
    applyStimulus(1, 32'h0040_0008, 1, 0, 32'h0, 1, 1, 0, 14'd2);
    applyStimulus(0, 32'h0,         1, 0, 32'h0, 1, 0, 0, 14'd2);

    // Data error paths: above range, misaligned, below range.
    applyStimulus(0, 32'h0, 1, 1, 32'h0041_0000, 1, 0, 1, 14'd2);
    applyStimulus(0, 32'h0, 1, 1, 32'h0040_0002, 1, 0, 1, 14'd2);
    applyStimulus(0, 32'h0, 1, 1, 32'h003F_FFFC, 1, 0, 1, 14'd2);
    // Last word of the region is in range.
    applyStimulus(1, 32'h0040_FFFC, 1, 0, 32'h0, 1, 1, 0, 14'h3FFF);
    applyStimulus(0, 32'h0,         1, 0, 32'h0, 1, 0, 0, 14'h3FFF);

    // Starvation: fetch wins four cycles, data wins the fifth, twice over.
    applyStimulus(1, 32'h0040_0010, 1, 1, 32'h0040_0100, 1, 1, 0, 14'd4);
    applyStimulus(1, 32'h0040_0014, 1, 1, 32'h0040_0100, 1, 1, 0, 14'd5);
    applyStimulus(1, 32'h0040_0018, 1, 1, 32'h0040_0100, 1, 1, 0, 14'd6);
    applyStimulus(1, 32'h0040_001C, 1, 1, 32'h0040_0100, 1, 1, 0, 14'd7);
    applyStimulus(1, 32'h0040_0020, 1, 1, 32'h0040_0100, 1, 0, 1, 14'h40);
    applyStimulus(1, 32'h0040_0020, 1, 1, 32'h0040_0104, 1, 1, 0, 14'd8);
    applyStimulus(1, 32'h0040_0024, 1, 1, 32'h0040_0104, 1, 1, 0, 14'd9);
    applyStimulus(1, 32'h0040_0028, 1, 1, 32'h0040_0104, 1, 1, 0, 14'd10);
    applyStimulus(1, 32'h0040_002C, 1, 1, 32'h0040_0104, 1, 1, 0, 14'd11);
    applyStimulus(1, 32'h0040_0030, 1, 1, 32'h0040_0104, 1, 0, 1, 14'h41);
    applyStimulus(0, 32'h0,         1, 0, 32'h0,         1, 0, 0, 14'h41);

    // Backpressure on fetch while data keeps reading every cycle.
    applyStimulus(1, 32'h0040_0040, 1, 1, 32'h0040_0200, 1, 1, 0, 14'h10);
    applyStimulus(1, 32'h0040_0044, 0, 1, 32'h0040_0200, 1, 0, 1, 14'h80);
    applyStimulus(1, 32'h0040_0044, 0, 1, 32'h0040_0204, 1, 0, 1, 14'h81);
    applyStimulus(1, 32'h0040_0044, 0, 1, 32'h0040_0208, 1, 0, 1, 14'h82);
    applyStimulus(1, 32'h0040_0044, 1, 1, 32'h0040_020C, 1, 1, 0, 14'h11);
    applyStimulus(0, 32'h0,         1, 0, 32'h0,         1, 0, 0, 14'h11);

    // Fetch error and data in-range accepted together, then reset mid-flight.
    applyStimulus(1, 32'h0040_0001, 1, 1, 32'h0040_0050, 1, 1, 1, 14'h14);
    #1 reset = 1'b1;
    if_req_valid = 1'b0;
    dt_req_valid = 1'b0;
    #1;
    checkOutput("midreset_if_rsp_valid", {31'd0, if_rsp_valid}, 32'd0);
    checkOutput("midreset_dt_rsp_valid", {31'd0, dt_rsp_valid}, 32'd0);
    checkOutput("midreset_mem_address", {18'd0, mem_address}, 32'd0);
    checkOutput("midreset_dt_rsp_data", dt_rsp_data, 32'd0);
    checkOutput("midreset_if_rsp_error", {31'd0, if_rsp_error}, 32'd0);
    @(posedge clock);
    #1 reset = 1'b0;

    // Post-reset requests complete normally with no stale responses.
    applyStimulus(1, 32'h0040_0060, 1, 1, 32'h0040_0064, 1, 1, 0, 14'h18);
    applyStimulus(0, 32'h0,         1, 1, 32'h0040_0064, 1, 0, 1, 14'h19);
    applyStimulus(0, 32'h0,         1, 0, 32'h0,         1, 0, 0, 14'h19);
    applyStimulus(0, 32'h0,         1, 0, 32'h0,         1, 0, 0, 14'h19);

    checkOutput("if_queue_drained", if_q.size(), 32'd0);
    checkOutput("dt_queue_drained", dt_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/text_memory_arbiter.md
# text_memory_arbiter

Two-port arbiter that shares the single-ported, synchronous-read text memory between instruction fetch and a data-side reader (loads from `.text`, debug reads). It sits between the core's fetch and load paths and the text memory. The arbiter checks address range and alignment, grants one port per cycle with fetch priority and a starvation guard, and returns responses through per-port valid/ready channels with hold buffering.

## Interface
Parameters:
- TEXT_BEGIN, 32'h0040_0000, first byte address of the text region
- TEXT_END, 32'h0040_FFFF, last byte address of the text region (inclusive)
- STARVE_LIMIT, 4, number of consecutive blocked cycles after which the data port wins arbitration (≥1)

Ports:
- clock  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high
- if_req_valid  in  1  fetch request valid
- if_req_ready  out  1  fetch request accepted this cycle
- if_req_addr  in  32  fetch byte address
- if_rsp_valid  out  1  fetch response valid
- if_rsp_ready  in  1  fetch consumer takes response
- if_rsp_data  out  32  fetch response word
- if_rsp_error  out  1  out-of-range or misaligned request
- dt_req_valid, dt_req_ready, dt_req_addr, dt_rsp_valid, dt_rsp_ready, dt_rsp_data, dt_rsp_error: data port, same widths and directions as the fetch port
- mem_address  out  14  word address to text memory (byte address [15:2])
- mem_q  in  32  text memory output, valid one cycle after mem_address is sampled

## Operation
- A request is in range when TEXT_BEGIN ≤ addr ≤ TEXT_END and addr[1:0]==0. Otherwise it is an error request.
- Error requests bypass arbitration. They are accepted whenever the port's response slot is free. The response is rsp_data=32'h0000_0000 with rsp_error=1. Error requests never drive mem_address.
- In-range requests compete for the memory:
  - Default winner is fetch.
  - Data wins when starve_cnt == STARVE_LIMIT, or when fetch has no in-range request.
  - At most one in-range grant per cycle.
- starve_cnt: increments (saturating at STARVE_LIMIT) each cycle the data port has an in-range request that is not accepted. It clears on a data in-range accept, on dt_req_valid low, and on reset.
- Response slot per port: free when no response is pending, or when the pending response is consumed this cycle (rsp_valid && rsp_ready).
  - req_ready = slot free && (error request || port granted).
  - An in-range request is accepted only if its response slot is free. A granted port with a full slot is not accepted; the other port may take the grant that cycle.
- mem_address = granted port's addr[15:2]. With no grant it holds the last granted word address (register, reset 0).
- Response hold: if rsp_valid && !rsp_ready, the arbiter captures mem_q into a per-port hold register. rsp_data and rsp_error stay stable until consumed, even if the memory is re-addressed by the other port.
- Per-port states:
  - IDLE → INFLIGHT on accept.
  - INFLIGHT → IDLE when the response is consumed, or stays INFLIGHT on a new back-to-back accept.
  - INFLIGHT → HOLD when not consumed.
  - HOLD → IDLE, or HOLD → INFLIGHT, when consumed (same-cycle re-accept allowed).

## Timing
- Latency: accept at edge N → rsp_valid high during cycle N+1. This holds for both in-range and error requests.
- Throughput: 1 request/cycle per port when rsp_ready is held high. Combined memory throughput is 1 in-range read/cycle.
- req_ready depends combinationally on req_valid, addr, rsp_ready and internal state. The rsp_* outputs are registered state or mem_q/hold muxes with no combinational path from req_*.
- Reset (asynchronous, any cycle):
  - State → IDLE; starve_cnt → 0; hold registers → 0.
  - rsp_valid=0, rsp_data=0, rsp_error=0, mem_address=0.
  - Both req_ready=0 while reset is high.
  - In-flight responses are dropped and never delivered.
- Simultaneous in-range requests with a fetch slot that is full: data is granted that cycle. starve_cnt is unaffected except that the data accept clears it.
- Simultaneous fetch error request and data in-range request: both are accepted in the same cycle.
- Address TEXT_END-3 is in range. Address TEXT_END+1 is an error. TEXT_BEGIN-4 is an error.

## Test plan
- Fetch only, in range: if_req_addr 0x0040_0000, 0x0040_0004, 0x0040_0008 back-to-back with rsp_ready=1 → mem_address 0,1,2. if_rsp_data equals memory words at 0,1,2 one cycle later. No bubbles.
- Error paths: dt_req_addr 0x0041_0000, then 0x0040_0002, then 0x003F_FFFC → each gets dt_rsp_valid next cycle with data 0x0 and error=1. mem_address is unchanged.
- Starvation: fetch and data both request in range every cycle, rsp_ready=1 → fetch wins 4 cycles, data wins in the 5th cycle, and the pattern repeats.
- Backpressure: if_rsp_ready=0 for 3 cycles after one fetch response while data reads continue → if_rsp_data is stable, if_req_ready=0, and data reads proceed each cycle. Dropping if_rsp_ready... raising it releases the fetch response, and a new fetch is accepted in that same cycle.
- Reset mid-operation: assert reset while both ports are INFLIGHT → all rsp_valid=0 and mem_address=0 immediately. After release, the first requests complete normally with no stale responses.
